vt_rng_ctrl: RTL and testbench
==============================

Name: vt_rng_ctrl

Overview:
Controller that sequences one V-trapezoid RNG core and shares its 18-bit sample stream among NREQ requesters.
- Owns the core's seed inputs and its active-low reset, so it performs seeding and reseeding.
- Masks out samples while the core's pipeline is filling.
- Hands each valid sample to at most one requester, using a registered round-robin arbiter.
- Sits between the RNG core and the consumer blocks; it is the only driver of the core's data, data2 and reset pins.

Parameters:
NREQ, 4, number of requesters (2..8).
FILL_LAT, 5, rising edges after core reset release before gen_x is valid.
SEED_HOLD, 2, cycles gen_reset is held low per seeding.
DEF_SEED, 39'h5A5A5A5A5, default/fallback 39-bit LFSR seed (nonzero).
DEF_SEED2, 16'hACE1, default/fallback 16-bit LFSR seed (nonzero).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
seed_in  in  39  new primary seed, sampled when reseed_req=1
seed2_in  in  16  new secondary seed, sampled when reseed_req=1
reseed_req  in  1  one-cycle request to reseed the core
gen_data  out  39  seed to core data pin (registered)
gen_data2  out  16  seed to core data2 pin (registered)
gen_reset  out  1  core reset, active-low, registered (glitch-free)
gen_x  in  18  core sample output
req  in  NREQ  per-requester level request
gnt  out  NREQ  one-hot grant, valid with sample
sample  out  18  granted sample
sample_valid  out  1  high the cycle a grant is issued
busy  out  1  high in SEED or FILL
seed_fix  out  1  sticky: a zero seed was replaced by the default; cleared on the next valid reseed

Behaviour:
- On reset=0 (async):
  - state=SEED, hold counter=0, gen_reset=0.
  - gen_data=DEF_SEED, gen_data2=DEF_SEED2.
  - gnt=0, sample=0, sample_valid=0, busy=1, seed_fix=0, rr pointer=0.
- SEED state:
  - gen_reset=0 for exactly SEED_HOLD cycles.
  - Then gen_reset rises (registered) and the block moves to FILL with fill counter=0.
- FILL state:
  - The counter increments on each edge with gen_reset=1.
  - When the counter reaches FILL_LAT, go to RUN.
  - The first RUN edge samples the gen_x produced by the seeded LFSR state.
  - busy=1 and gnt=0 throughout.
- RUN state (busy=0), on each edge:
  - If req≠0, the winner is the first set bit at or after the rr pointer, wrapping at NREQ-1 to 0.
  - gnt<=onehot(winner), sample<=gen_x, sample_valid<=1, rr pointer<=(winner+1) mod NREQ.
  - If req=0: gnt<=0, sample_valid<=0, sample holds, pointer holds.
- Each gen_x value is granted at most once, because the core advances every cycle. Unrequested samples are discarded.
- Requesters consume one sample per granted cycle. A requester holding req continuously shares bandwidth fairly; with k active requesters each is served once per k cycles.
- reseed_req=1 (in any state, registered):
  - Latch seed_in and seed2_in into gen_data and gen_data2.
  - Enter SEED with hold counter=0; gen_reset<=0 on the same edge; gnt<=0, sample_valid<=0.
  - In RUN, reseed_req has priority over any grant in that cycle.
  - In SEED, it re-latches the seeds and restarts the hold count.
  - In FILL, it aborts the fill.
- Zero-seed rule:
  - If seed_in==0, DEF_SEED is used; if seed2_in==0, DEF_SEED2 is used.
  - Either substitution sets seed_fix=1.
  - A reseed with both seeds nonzero clears seed_fix.
- rr pointer is not reset by reseed. sample retains its last value across reseed.
- Latency: a req asserted before edge N in RUN gives gnt/sample after edge N (one cycle).
- NREQ=1 degenerates to a valid-qualified pass-through.

Test Plan:
- Reset release with req=0 → gen_reset low for 2 cycles, gen_data=DEF_SEED, busy falls exactly 2+5 edges later, gnt=0 throughout.
- After fill with req=4'b1111 held for 8 cycles → gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000, and each sample equals gen_x at that edge.
- rr pointer=2 and req=4'b0011 → gnt=0001 then 0010; then req=4'b1000 → gnt=1000 and pointer=0.
- Reseed with seed_in=39'h1, seed2_in=16'h1 while req=4'b0001 in RUN → no grant that cycle, gen_reset low 2 cycles, gen_data=1, gen_data2=1, first post-fill sample matches a golden core model seeded 1/1, seed_fix=0.
- Reseed with seed_in=0, seed2_in=16'h1234 → gen_data=DEF_SEED, gen_data2=16'h1234, seed_fix=1; a later reseed with both seeds nonzero → seed_fix=0.
- reseed_req pulsed at FILL count 3, then again at SEED hold cycle 1 → fill aborts, hold restarts, busy stays high, final seeds equal the second values, RUN entered 2+5 edges after the last pulse.

Source files
------------

// File: rtl/vt_rng_ctrl.sv
// vt_rng_ctrl: seeds and sequences one V-trapezoid RNG core, masks samples
// while the core pipeline fills, and hands each valid sample to at most one
// of NREQ requesters through a registered round-robin arbiter.
//
// Handshake: the sample port is push-only (valid without ready). In a cycle
// where sample_valid=1, exactly one gnt bit is set and that requester owns
// 'sample'. A requester keeps 'req' high for as long as it wants samples.
// Samples that nobody requests are dropped, because the core advances every
// cycle whether or not anyone consumes its output.
module vt_rng_ctrl #(
  parameter int          NREQ      = 4,
  parameter int          FILL_LAT  = 5,
  parameter int          SEED_HOLD = 2,
  parameter logic [38:0] DEF_SEED  = 39'h5A5A5A5A5,
  parameter logic [15:0] DEF_SEED2 = 16'hACE1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [38:0]     seed_in,
  input  logic [15:0]     seed2_in,
  input  logic            reseed_req,
  output logic [38:0]     gen_data,
  output logic [15:0]     gen_data2,
  output logic            gen_reset,
  input  logic [17:0]     gen_x,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [17:0]     sample,
  output logic            sample_valid,
  output logic            busy,
  output logic            seed_fix,
  output logic [1:0]      state_dbg
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (SEED_HOLD > FILL_LAT) ? SEED_HOLD : FILL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            gen_reset_next;
  logic            grant_en;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   next_ptr;
  logic [PW-1:0]   win_idx;
  logic            win_found;
  logic [PW:0]     cand;

  assign busy      = (state != ST_RUN);
  assign state_dbg = state;

  // Round-robin search: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(i);
      if (cand >= (PW+1)'(NREQ)) begin
        cand = cand - (PW+1)'(NREQ);
      end
      if (!win_found && req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  // Pointer moves one past the winner so the winner goes to the back of the line.
  always_comb begin
    next_ptr = '0;
    if (win_idx != PW'(NREQ - 1)) begin
      next_ptr = win_idx + PW'(1);
    end
  end

  // Next-state logic; a reseed request overrides whatever the state would do.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    gen_reset_next = gen_reset;
    grant_en       = 1'b0;
    if (reseed_req) begin
      state_next     = ST_SEED;
      cnt_next       = '0;
      gen_reset_next = 1'b0;
    end else begin
      case (state)
        ST_SEED: begin
          gen_reset_next = 1'b0;
          if (cnt >= CW'(SEED_HOLD - 1)) begin
            state_next     = ST_FILL;
            cnt_next       = '0;
            gen_reset_next = 1'b1;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
        ST_FILL: begin
          // gen_reset is high for the whole fill, so every edge counts.
          cnt_next = cnt + CW'(1);
          if (cnt_next >= CW'(FILL_LAT)) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          grant_en = win_found;
        end
        default: begin
          state_next     = ST_SEED;
          cnt_next       = '0;
          gen_reset_next = 1'b0;
        end
      endcase
    end
  end

  // State register plus the sequencing counter and the registered core reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_SEED;
      cnt       <= '0;
      gen_reset <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      gen_reset <= gen_reset_next;
    end
  end

  // Seed registers; an all-zero seed would lock the LFSR, so it is replaced.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gen_data  <= DEF_SEED;
      gen_data2 <= DEF_SEED2;
      seed_fix  <= 1'b0;
    end else if (reseed_req) begin
      gen_data  <= (seed_in == '0) ? DEF_SEED : seed_in;
      gen_data2 <= (seed2_in == '0) ? DEF_SEED2 : seed2_in;
      seed_fix  <= (seed_in == '0) || (seed2_in == '0);
    end
  end

  // Grant datapath; sample and rr_ptr hold whenever no grant is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      rr_ptr       <= '0;
    end else if (grant_en) begin
      gnt          <= NREQ'(1) << win_idx;
      sample       <= gen_x;
      sample_valid <= 1'b1;
      rr_ptr       <= next_ptr;
    end else begin
      gnt          <= '0;
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vt_rng_ctrl.sv
// tb_vt_rng_ctrl: drives vt_rng_ctrl together with a behavioural RNG core
// (two LFSRs feeding a FILL_LAT-deep output pipeline) and scoreboards grants.
module tb_vt_rng_ctrl;

  localparam int          NREQ      = 4;
  localparam int          FILL_LAT  = 5;
  localparam int          SEED_HOLD = 2;
  localparam logic [38:0] DEF_SEED  = 39'h5A5A5A5A5;
  localparam logic [15:0] DEF_SEED2 = 16'hACE1;
  localparam int          W         = 1 + NREQ + 18;

  logic            clk;
  logic            reset;
  logic [38:0]     seed_in;
  logic [15:0]     seed2_in;
  logic            reseed_req;
  logic [38:0]     gen_data;
  logic [15:0]     gen_data2;
  logic            gen_reset;
  logic [17:0]     gen_x;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [17:0]     sample;
  logic            sample_valid;
  logic            busy;
  logic            seed_fix;
  logic [1:0]      state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  int           exp_ptr    = 0;
  logic [17:0]  exp_sample = '0;

  vt_rng_ctrl #(
    .NREQ(NREQ), .FILL_LAT(FILL_LAT), .SEED_HOLD(SEED_HOLD),
    .DEF_SEED(DEF_SEED), .DEF_SEED2(DEF_SEED2)
  ) dut (
    .clk(clk), .reset(reset), .seed_in(seed_in), .seed2_in(seed2_in),
    .reseed_req(reseed_req), .gen_data(gen_data), .gen_data2(gen_data2),
    .gen_reset(gen_reset), .gen_x(gen_x), .req(req), .gnt(gnt),
    .sample(sample), .sample_valid(sample_valid), .busy(busy),
    .seed_fix(seed_fix), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural RNG core ----------------
  function automatic logic [17:0] core_mix(input logic [38:0] a, input logic [15:0] b);
    return a[17:0] ^ a[38:21] ^ {b, b[15:14]};
  endfunction

  logic [38:0] core_a;
  logic [15:0] core_b;
  logic [17:0] core_pipe [FILL_LAT];

  always @(posedge clk) begin
    if (!gen_reset) begin
      core_a <= gen_data;
      core_b <= gen_data2;
      for (int i = 0; i < FILL_LAT; i++) core_pipe[i] <= '0;
    end else begin
      core_a       <= {core_a[37:0], core_a[38] ^ core_a[34]};
      core_b       <= {core_b[14:0], core_b[15] ^ core_b[13] ^ core_b[12] ^ core_b[10]};
      core_pipe[0] <= core_mix(core_a, core_b);
      for (int i = 1; i < FILL_LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
  end
  assign gen_x = core_pipe[FILL_LAT-1];

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One RUN cycle: drive req, predict the grant, push it, then pop and compare.
  task automatic drive_cycle(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] g;
    logic [17:0]     s;
    logic            v;
    logic [W-1:0]    want;
    int              w;
    int              c;
    req = r;
    g   = '0;
    v   = 1'b0;
    s   = exp_sample;
    w   = -1;
    for (int i = 0; i < NREQ; i++) begin
      c = (exp_ptr + i) % NREQ;
      if (w < 0 && r[c]) w = c;
    end
    if (w >= 0) begin
      g          = NREQ'(1) << w;
      v          = 1'b1;
      s          = gen_x;
      exp_ptr    = (w + 1) % NREQ;
      exp_sample = s;
    end
    exp_q.push_back({v, g, s});
    @(posedge clk);
    @(negedge clk);
    want = exp_q.pop_front();
    check_eq("grant", 64'({sample_valid, gnt, sample}), 64'(want));
  endtask

  // Pulse reseed_req for one edge, then check the immediate effects.
  task automatic do_reseed(input logic [38:0] s1, input logic [15:0] s2);
    seed_in    = s1;
    seed2_in   = s2;
    reseed_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reseed_req = 1'b0;
    check_eq("rs_valid", 64'(sample_valid), 64'(0));
    check_eq("rs_gnt", 64'(gnt), 64'(0));
    check_eq("rs_genrst", 64'(gen_reset), 64'(0));
    check_eq("rs_busy", 64'(busy), 64'(1));
    check_eq("rs_sample_hold", 64'(sample), 64'(exp_sample));
    check_eq("rs_data", 64'(gen_data), 64'((s1 == '0) ? DEF_SEED : s1));
    check_eq("rs_data2", 64'(gen_data2), 64'((s2 == '0) ? DEF_SEED2 : s2));
    check_eq("rs_fix", 64'(seed_fix), 64'((s1 == '0) || (s2 == '0)));
  endtask

  // Count edges until busy falls; gen_reset must rise after SEED_HOLD edges.
  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
      if (n == SEED_HOLD - 1) check_eq("hold_low", 64'(gen_reset), 64'(0));
      if (n == SEED_HOLD)     check_eq("hold_rise", 64'(gen_reset), 64'(1));
      check_eq("fill_gnt", 64'(gnt), 64'(0));
    end
    check_eq(tag, 64'(n), 64'(SEED_HOLD + FILL_LAT));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset      = 1'b0;
    req        = '0;
    reseed_req = 1'b0;
    seed_in    = '0;
    seed2_in   = '0;
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_genrst", 64'(gen_reset), 64'(0));
    check_eq("rst_data", 64'(gen_data), 64'(DEF_SEED));
    check_eq("rst_data2", 64'(gen_data2), 64'(DEF_SEED2));
    check_eq("rst_busy", 64'(busy), 64'(1));
    check_eq("rst_gnt", 64'(gnt), 64'(0));
    check_eq("rst_valid", 64'(sample_valid), 64'(0));
    check_eq("rst_sample", 64'(sample), 64'(0));
    check_eq("rst_fix", 64'(seed_fix), 64'(0));

    // reset release: gen_reset rises after 2 edges, busy falls after 2+5
    reset = 1'b1;
    for (int k = 1; k <= SEED_HOLD + FILL_LAT; k++) begin
      @(negedge clk);
      check_eq("rel_genrst", 64'(gen_reset), 64'((k >= SEED_HOLD) ? 1 : 0));
      check_eq("rel_busy", 64'(busy), 64'((k >= SEED_HOLD + FILL_LAT) ? 0 : 1));
      check_eq("rel_gnt", 64'(gnt), 64'(0));
    end

    // all four requesting for 8 cycles: strict rotation 0001..1000 twice
    for (int k = 0; k < 8; k++) begin
      drive_cycle(4'b1111);
      check_eq("rot_gnt", 64'(gnt), 64'(4'b0001 << (k % 4)));
      if (k == 0) check_eq("first_sample", 64'(sample), 64'(core_mix(DEF_SEED, DEF_SEED2)));
    end

    // pointer to 2, then 0011 wraps to 0001 then 0010; then 1000 -> pointer 0
    drive_cycle(4'b0010);
    drive_cycle(4'b0011);
    check_eq("wrap_a", 64'(gnt), 64'(4'b0001));
    drive_cycle(4'b0011);
    check_eq("wrap_b", 64'(gnt), 64'(4'b0010));
    drive_cycle(4'b1000);
    check_eq("wrap_c", 64'(gnt), 64'(4'b1000));
    drive_cycle(4'b0000);
    drive_cycle(4'b1111);
    check_eq("ptr_zero", 64'(gnt), 64'(4'b0001));

    // random request patterns
    for (int k = 0; k < 16; k++) drive_cycle(NREQ'($urandom_range(0, (1 << NREQ) - 1)));

    // reseed 1/1 with a pending request: no grant, refill, golden first sample
    req = 4'b0001;
    do_reseed(39'h1, 16'h1);
    wait_run("run_lat_a");
    drive_cycle(4'b0001);
    check_eq("golden_1_1", 64'(sample), 64'(core_mix(39'h1, 16'h1)));

    // zero-seed substitution and its clearing
    do_reseed(39'h0, 16'h1234);
    wait_run("run_lat_b");
    check_eq("fix_sticky", 64'(seed_fix), 64'(1));
    do_reseed(39'h123456789, 16'h0);
    wait_run("run_lat_c");
    do_reseed(39'h123456789, 16'h55AA);
    wait_run("run_lat_d");
    check_eq("fix_clear", 64'(seed_fix), 64'(0));

    // abort in FILL at count 3, then restart in SEED at hold cycle 1
    req = 4'b0000;
    do_reseed(39'h11111, 16'h2222);
    repeat (SEED_HOLD + 3) begin
      @(negedge clk);
      check_eq("abort_busy", 64'(busy), 64'(1));
    end
    do_reseed(39'h33333, 16'h4444);
    @(negedge clk);
    check_eq("abort_busy2", 64'(busy), 64'(1));
    do_reseed(39'h7654321, 16'hBEEF);
    wait_run("run_lat_e");
    drive_cycle(4'b0100);
    check_eq("golden_last", 64'(sample), 64'(core_mix(39'h7654321, 16'hBEEF)));
    for (int k = 0; k < 8; k++) drive_cycle(NREQ'($urandom_range(0, (1 << NREQ) - 1)));

    check_eq("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish, expected done by %0t", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
